// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings and
// register window offsets.
package int_ctrl_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_MODE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CFG_W = 16;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set
// request bit plus a valid flag.
module prio_enc #(
  parameter int N_INT = 8,
  parameter int VEC_W = 3
) (
  input  logic [N_INT-1:0] req,
  output logic             vld,
  output logic [VEC_W-1:0] vec
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    vld = 1'b0;
    vec = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        vec = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: pin synchroniser, edge/level pending
// logic, request/ack/eoi handshake FSM and a 4-word config register window.
module int_ctrl
  import int_ctrl_defs::*;
#(
  parameter int N_INT = 8,
  parameter int VEC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_INT-1:0] irq_in,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic [15:0]      cfg_rdata,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic             irq_eoi
);

  localparam logic [CFG_W-1:0] LEGAL = CFG_W'((32'd1 << N_INT) - 32'd1);

  logic [N_INT-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [CFG_W-1:0] enable_q, enable_d, mode_q, mode_d;
  logic [N_INT-1:0] pend_q, pend_d;
  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;

  logic [N_INT-1:0] pend, elig, rise, clr;
  logic             enc_vld;
  logic [VEC_W-1:0] enc_vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      state_q  <= ST_IDLE;
      vec_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      vec_q    <= vec_d;
    end
  end

  // Level sources use the third stage so edge and level paths share latency.
  always_comb begin
    sync1_d  = irq_in;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    rise     = sync2_q & ~sync3_q;
    pend     = (pend_q & mode_q[N_INT-1:0]) | (sync3_q & ~mode_q[N_INT-1:0]);
    elig     = pend & enable_q[N_INT-1:0];
    enable_d = enable_q;
    mode_d   = mode_q;
    clr      = '0;
    if (cfg_wr) begin
      case (cfg_addr)
        REG_ENABLE:  enable_d = cfg_wdata & LEGAL;
        REG_MODE:    mode_d   = cfg_wdata & LEGAL;
        REG_PENDING: clr      = cfg_wdata[N_INT-1:0];
        default:     ;
      endcase
    end
    if (state_q == ST_REQ && irq_ack) clr[vec_q] = 1'b1;
    // Set beats clear; level-mode bits keep no storage.
    pend_d = mode_q[N_INT-1:0] & ((pend_q & ~clr) | rise);
  end

  prio_enc #(.N_INT(N_INT), .VEC_W(VEC_W)) u_prio (
    .req (elig),
    .vld (enc_vld),
    .vec (enc_vec)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          state_d = ST_REQ;
          vec_d   = enc_vec;
        end
      end
      // An ack in the same cycle as a withdraw still wins.
      ST_REQ: begin
        if (irq_ack)            state_d = ST_SERVICE;
        else if (!elig[vec_q])  state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (irq_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign irq_req = (state_q == ST_REQ);
  assign irq_vec = vec_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_ENABLE:  cfg_rdata = enable_q;
      REG_MODE:    cfg_rdata = mode_q;
      REG_PENDING: cfg_rdata[N_INT-1:0] = pend;
      REG_STATUS:  cfg_rdata[2:0] = {state_q, state_q == ST_SERVICE};
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a cycle-level behavioural reference model
// compared every cycle, plus literal expectations at the key handshake points.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq_in = '0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic        irq_req;
  logic [2:0]  irq_vec;
  logic        irq_ack = 1'b0;
  logic        irq_eoi = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  int_ctrl #(.N_INT(8), .VEC_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // p0/p1/p2: pin value seen at the last, second-last and third-last edge.
  logic [7:0] p0 = '0, p1 = '0, p2 = '0;
  logic [7:0] m_en = '0, m_mode = '0, m_store = '0;
  int         m_st = 0;              // 0 idle, 1 requesting, 2 in service
  logic [2:0] m_vec = '0;
  bit         started = 1'b0;

  function automatic logic [7:0] m_visible();
    return (m_store & m_mode) | (p2 & ~m_mode);
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [15:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0: return {8'h00, m_en};
      2'd1: return {8'h00, m_mode};
      2'd2: return {8'h00, m_visible()};
      default: return 16'(m_st * 2 + ((m_st == 2) ? 1 : 0));
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] elig, clr, rise;
    int         nst;
    logic [2:0] nvec;
    started = 1'b1;
    if (!rst_n) begin
      p0 = '0; p1 = '0; p2 = '0;
      m_en = '0; m_mode = '0; m_store = '0;
      m_st = 0; m_vec = '0;
    end else begin
      elig = m_visible() & m_en;
      rise = p1 & ~p2;
      clr  = '0;
      if (cfg_wr && cfg_addr == 2'd2) clr = cfg_wdata[7:0];
      if (m_st == 1 && irq_ack) clr[m_vec] = 1'b1;
      nst = m_st; nvec = m_vec;
      if (m_st == 0 && elig != 0) begin nst = 1; nvec = lowest(elig); end
      else if (m_st == 1 && irq_ack) nst = 2;
      else if (m_st == 1 && !elig[m_vec]) nst = 0;
      else if (m_st == 2 && irq_eoi) nst = 0;
      m_store = m_mode & ((m_store & ~clr) | rise);
      if (cfg_wr && cfg_addr == 2'd0) m_en = cfg_wdata[7:0];
      if (cfg_wr && cfg_addr == 2'd1) m_mode = cfg_wdata[7:0];
      p2 = p1; p1 = p0; p0 = irq_in;
      m_st = nst; m_vec = nvec;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model irq_req", 32'(irq_req), 32'(m_st == 1));
      if (m_st != 0) chk("model irq_vec", 32'(irq_vec), 32'(m_vec));
      chk("model cfg_rdata", 32'(cfg_rdata), 32'(m_rdata(cfg_addr)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [15:0] exp);
    cfg_addr = a; #1;
    chk(nm, 32'(cfg_rdata), 32'(exp));
  endtask

  task automatic pulse_pin(input logic [7:0] m);
    irq_in = irq_in | m; tick(); irq_in = irq_in & ~m;
  endtask

  task automatic ack(); irq_ack = 1'b1; tick(); irq_ack = 1'b0; endtask
  task automatic eoi(); irq_eoi = 1'b1; tick(); irq_eoi = 1'b0; endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!irq_req && n < 12) begin tick(); n++; end
    chk(nm, 32'(irq_req), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset irq_req", 32'(irq_req), 32'd0);
    chk("reset irq_vec", 32'(irq_vec), 32'd0);
    rd("reset ENABLE", 2'd0, 16'h0000);
    rd("reset STATUS", 2'd3, 16'h0000);

    // 1: edge source latency and handshake
    wr(2'd0, 16'hFFFF);
    rd("ENABLE upper bits masked", 2'd0, 16'h00FF);
    wr(2'd1, 16'h00FF);
    rd("MODE readback", 2'd1, 16'h00FF);
    cfg_addr = 2'd2;
    pulse_pin(8'h08);                                   // edge 1
    tick(); rd("t1 pend after e2", 2'd2, 16'h0000);     // edge 2
    tick(); rd("t1 pend after e3", 2'd2, 16'h0008);     // edge 3
    chk("t1 no req after e3", 32'(irq_req), 32'd0);
    tick();                                             // edge 4
    chk("t1 req after e4", 32'(irq_req), 32'd1);
    chk("t1 vec", 32'(irq_vec), 32'd3);
    ack();
    rd("t1 pend after ack", 2'd2, 16'h0000);
    rd("t1 STATUS service", 2'd3, 16'h0005);
    eoi();
    rd("t1 STATUS idle", 2'd3, 16'h0000);

    // 2: simultaneous sources, lowest index first
    pulse_pin(8'h24);
    repeat (3) tick();
    chk("t2 first req", 32'(irq_req), 32'd1);
    chk("t2 first vec", 32'(irq_vec), 32'd2);
    ack();
    rd("t2 pend keeps 5", 2'd2, 16'h0020);
    eoi();
    chk("t2 no req on eoi edge", 32'(irq_req), 32'd0);
    tick();
    chk("t2 second req", 32'(irq_req), 32'd1);
    chk("t2 second vec", 32'(irq_vec), 32'd5);
    ack(); eoi();

    // 3: level source re-asserts, then withdraws
    wr(2'd1, 16'h0000);
    irq_in = 8'h02;
    wait_req("t3 level req");
    chk("t3 vec", 32'(irq_vec), 32'd1);
    ack(); eoi();
    chk("t3 idle after eoi", 32'(irq_req), 32'd0);
    tick();
    chk("t3 re-assert", 32'(irq_req), 32'd1);
    chk("t3 re-assert vec", 32'(irq_vec), 32'd1);
    irq_in = 8'h00;
    repeat (3) tick();
    chk("t3 still req after e3", 32'(irq_req), 32'd1);
    tick();
    chk("t3 withdrawn", 32'(irq_req), 32'd0);
    rd("t3 STATUS idle", 2'd3, 16'h0000);

    // 4: disabled source stays pending; W1C and set-wins
    wr(2'd1, 16'h00FF);
    wr(2'd0, 16'h0000);
    pulse_pin(8'h40);
    repeat (3) tick();
    chk("t4 no req", 32'(irq_req), 32'd0);
    rd("t4 pending set", 2'd2, 16'h0040);
    wr(2'd2, 16'h0040);
    rd("t4 pending cleared", 2'd2, 16'h0000);
    pulse_pin(8'h40);                                   // edge 1
    tick();                                             // edge 2
    wr(2'd2, 16'h0040);                                 // W1C lands on edge 3
    rd("t4 set beats clear", 2'd2, 16'h0040);
    wr(2'd2, 16'h0040);
    rd("t4 final clear", 2'd2, 16'h0000);

    // 5: no nesting; stray ack ignored
    wr(2'd0, 16'h00FF);
    pulse_pin(8'h08);
    wait_req("t5 req");
    ack();
    pulse_pin(8'h01);
    repeat (5) tick();
    chk("t5 no nesting", 32'(irq_req), 32'd0);
    rd("t5 pending 0", 2'd2, 16'h0001);
    ack();
    rd("t5 stray ack STATUS", 2'd3, 16'h0005);
    rd("t5 stray ack pending", 2'd2, 16'h0001);
    eoi();
    chk("t5 idle on eoi", 32'(irq_req), 32'd0);
    tick();
    chk("t5 next req", 32'(irq_req), 32'd1);
    chk("t5 next vec", 32'(irq_vec), 32'd0);
    ack(); eoi();

    // 6: reset mid-handshake
    pulse_pin(8'h10);
    wait_req("t6 req");
    chk("t6 vec", 32'(irq_vec), 32'd4);
    rst_n = 1'b0;
    tick();
    chk("t6 reset req", 32'(irq_req), 32'd0);
    rd("t6 reset pending", 2'd2, 16'h0000);
    rd("t6 reset enable", 2'd0, 16'h0000);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
